// File: rtl/dp_cache_responder.sv
// Stand-in cache for the pipelined datapath: serialises instruction fetches and
// data accesses onto one single-ported RAM and answers each with a hit pulse.
module dp_cache_responder #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              dhit,
  output logic [WORD_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [WORD_W-1:0] addr_reg;
  logic [WORD_W-1:0] store_reg;
  logic              write_reg;
  logic [WORD_W-1:0] imemload_reg;
  logic [WORD_W-1:0] dmemload_reg;
  logic              latch_d;
  logic              latch_i;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strobes and hits decode from the state register alone, so an asynchronous
  // reset drops them immediately and the datapath never sees a partial hit.
  always_comb begin
    state_next = state_reg;
    latch_d    = 1'b0;
    latch_i    = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          latch_d    = 1'b1;
          state_next = DACC;
        end else if (imemREN && !halt) begin
          latch_i    = 1'b1;
          state_next = IACC;
        end
      end
      DACC: begin
        ramREN = !write_reg;
        ramWEN = write_reg;
        if (ram_ready) state_next = DRESP;
      end
      IACC: begin
        ramREN = 1'b1;
        if (ram_ready) state_next = IRESP;
      end
      DRESP: begin
        dhit       = 1'b1;
        state_next = IDLE;
      end
      IRESP: begin
        ihit       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write wins when both data strobes are raised; the fetch leaves store_reg alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_reg     <= '0;
      store_reg    <= '0;
      write_reg    <= 1'b0;
      imemload_reg <= '0;
      dmemload_reg <= '0;
    end else begin
      if (latch_d) begin
        addr_reg  <= dmemaddr;
        store_reg <= dmemstore;
        write_reg <= dmemWEN;
      end else if (latch_i) begin
        addr_reg  <= imemaddr;
        write_reg <= 1'b0;
      end
      if (state_reg == DACC && ram_ready && !write_reg) dmemload_reg <= ramload;
      if (state_reg == IACC && ram_ready) imemload_reg <= ramload;
    end
  end

  assign ramaddr  = addr_reg;
  assign ramstore = store_reg;
  assign imemload = imemload_reg;
  assign dmemload = dmemload_reg;

endmodule

// File: tb/tb_dp_cache_responder.sv
// Bench for dp_cache_responder: behavioural variable-latency RAM, a hit
// scoreboard, and one task per scenario.
module tb_dp_cache_responder;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST = 1'b1;
  logic         halt = 1'b0;
  logic         imemREN = 1'b0;
  logic [W-1:0] imemaddr = '0;
  logic         dmemREN = 1'b0;
  logic         dmemWEN = 1'b0;
  logic [W-1:0] dmemaddr = '0;
  logic [W-1:0] dmemstore = '0;
  logic [W-1:0] ramload = '0;
  logic         ram_ready = 1'b0;
  logic         ihit, dhit, ramREN, ramWEN;
  logic [W-1:0] imemload, dmemload, ramaddr, ramstore;

  typedef struct packed {
    logic         is_d;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [W-1:0] mon_got;
  logic [W-1:0] exp_dload = '0;
  logic [W-1:0] mem [bit [31:0]];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_ren = 0;
  int           ram_lat = 1;
  int           ram_cnt = 0;

  dp_cache_responder #(.WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA5A5_0000 ^ a;
  endfunction

  // RAM model: ready after ram_lat cycles of a held strobe
  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      ram_cnt = ram_cnt + 1;
      ramload = ramREN ? mem_rd(ramaddr) : '0;
      if (ram_cnt == ram_lat) begin
        ram_ready = 1'b1;
        if (ramWEN) mem[ramaddr] = ramstore;
      end else begin
        ram_ready = 1'b0;
      end
    end else begin
      ram_cnt   = 0;
      ram_ready = 1'b0;
    end
  end

  // Scoreboard: every hit pops one expected transaction
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (ramREN) n_ren = n_ren + 1;
      if (ihit && dhit) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL hit_exclusive: ihit=1 dhit=1, required at most one high");
      end
      if (ihit || dhit) begin
        if (sb_q.size() == 0) begin
          n_cmp = n_cmp + 1;
          n_err = n_err + 1;
          $display("FAIL unexpected_hit: ihit=%0b dhit=%0b with nothing pending", ihit, dhit);
        end else begin
          mon_e   = sb_q.pop_front();
          mon_got = dhit ? dmemload : imemload;
          n_cmp   = n_cmp + 1;
          if (dhit !== mon_e.is_d || mon_got !== mon_e.data) begin
            n_err = n_err + 1;
            $display("FAIL sb_hit: got dhit=%0b load=%h, required dhit=%0b load=%h",
                     dhit, mon_got, mon_e.is_d, mon_e.data);
          end else begin
            $display("txn %s load=%h", mon_e.is_d ? "data" : "inst", mon_got);
          end
        end
      end
    end
  end

  task automatic test_reset;
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
      n_err = n_err + 1;
      $display("FAIL reset_ctrl: got %b, required 0000", {ihit, dhit, ramREN, ramWEN});
    end
    n_cmp = n_cmp + 1;
    if ({imemload, dmemload, ramaddr, ramstore} !== '0) begin
      n_err = n_err + 1;
      $display("FAIL reset_data: got %h %h %h %h, required all 0", imemload, dmemload, ramaddr, ramstore);
    end
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
      n_err = n_err + 1;
      $display("FAIL reset_idle: got %b, required 0000", {ihit, dhit, ramREN, ramWEN});
    end
  endtask

  task automatic test_fetch_basic;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0004;
    sb_q.push_back('{1'b0, 32'h2001_0005});
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h4 || ihit !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL fetch_acc: got ren=%b wen=%b addr=%h ihit=%b, required 1 0 00000004 0",
               ramREN, ramWEN, ramaddr, ihit);
    end
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ihit !== 1'b1 || ramREN !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL fetch_hit: got ihit=%b ren=%b, required 1 0", ihit, ramREN);
    end
    imemREN = 1'b0;
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ihit !== 1'b0 || ramREN !== 1'b0 || imemload !== 32'h2001_0005) begin
      n_err = n_err + 1;
      $display("FAIL fetch_after: got ihit=%b ren=%b load=%h, required 0 0 20010005", ihit, ramREN, imemload);
    end
  endtask

  task automatic test_priority;
    @(negedge CLK);
    dmemREN  = 1'b1;
    dmemaddr = 32'h80;
    imemREN  = 1'b1;
    imemaddr = 32'h10;
    sb_q.push_back('{1'b1, 32'hDEAD_BEEF});
    sb_q.push_back('{1'b0, 32'h8C22_0000});
    exp_dload = 32'hDEAD_BEEF;
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h80) begin
      n_err = n_err + 1;
      $display("FAIL prio_dacc: got ren=%b wen=%b addr=%h, required 1 0 00000080", ramREN, ramWEN, ramaddr);
    end
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (dhit !== 1'b1 || ihit !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL prio_dhit: got dhit=%b ihit=%b, required 1 0", dhit, ihit);
    end
    dmemREN = 1'b0;
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ramREN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL prio_idle: got ren=%b ihit=%b dhit=%b, required 0 0 0", ramREN, ihit, dhit);
    end
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin
      n_err = n_err + 1;
      $display("FAIL prio_iacc: got ren=%b addr=%h, required 1 00000010", ramREN, ramaddr);
    end
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ihit !== 1'b1 || dmemload !== 32'hDEAD_BEEF) begin
      n_err = n_err + 1;
      $display("FAIL prio_ihit: got ihit=%b dload=%h, required 1 deadbeef", ihit, dmemload);
    end
    imemREN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write_wait;
    @(negedge CLK);
    ram_lat   = 5;
    dmemWEN   = 1'b1;
    dmemaddr  = 32'hF0;
    dmemstore = 32'h1234_5678;
    sb_q.push_back('{1'b1, exp_dload});
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      n_cmp = n_cmp + 1;
      if ({ramWEN, ramREN, dhit} !== 3'b100 || ramaddr !== 32'hF0 || ramstore !== 32'h1234_5678) begin
        n_err = n_err + 1;
        $display("FAIL write_acc%0d: got wen/ren/dhit=%b addr=%h data=%h, required 100 000000f0 12345678",
                 i, {ramWEN, ramREN, dhit}, ramaddr, ramstore);
      end
    end
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (dhit !== 1'b1 || ramWEN !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL write_dhit: got dhit=%b wen=%b, required 1 0", dhit, ramWEN);
    end
    dmemWEN = 1'b0;
    ram_lat = 1;
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (mem_rd(32'hF0) !== 32'h1234_5678 || dmemload !== exp_dload) begin
      n_err = n_err + 1;
      $display("FAIL write_result: got mem=%h dload=%h, required 12345678 %h",
               mem_rd(32'hF0), dmemload, exp_dload);
    end
  endtask

  task automatic test_halt;
    bit got;
    int bad;
    @(negedge CLK);
    halt      = 1'b1;
    imemREN   = 1'b1;
    imemaddr  = 32'h20;
    dmemWEN   = 1'b1;
    dmemaddr  = 32'h40;
    dmemstore = 32'hCAFE_F00D;
    sb_q.push_back('{1'b1, exp_dload});
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (dhit) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp = n_cmp + 1;
    if (!got) begin
      n_err = n_err + 1;
      $display("FAIL halt_store: got no dhit in 10 cycles, required one");
    end
    dmemWEN = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (ihit || ramREN || ramWEN) bad++;
    end
    n_cmp = n_cmp + 1;
    if (bad != 0) begin
      n_err = n_err + 1;
      $display("FAIL halt_block: got %0d active cycles while halted, required 0", bad);
    end
    n_cmp = n_cmp + 1;
    if (mem_rd(32'h40) !== 32'hCAFE_F00D) begin
      n_err = n_err + 1;
      $display("FAIL halt_drain: got mem=%h, required cafef00d", mem_rd(32'h40));
    end
    sb_q.push_back('{1'b0, 32'h3C01_1234});
    halt = 1'b0;
    got  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ihit) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp = n_cmp + 1;
    if (!got) begin
      n_err = n_err + 1;
      $display("FAIL halt_release: got no ihit in 10 cycles, required one");
    end
    imemREN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge CLK);
    ram_lat  = 8;
    imemREN  = 1'b1;
    imemaddr = 32'h30;
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (ramREN !== 1'b1 || ramaddr !== 32'h30) begin
      n_err = n_err + 1;
      $display("FAIL rstmid_acc: got ren=%b addr=%h, required 1 00000030", ramREN, ramaddr);
    end
    #2 nRST = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if (ramREN !== 1'b0 || ihit !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL rstmid_drop: got ren=%b ihit=%b, required 0 0", ramREN, ihit);
    end
    imemREN   = 1'b0;
    exp_dload = '0;
    @(negedge CLK);
    @(negedge CLK);
    nRST    = 1'b1;
    ram_lat = 1;
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000 ||
        {imemload, dmemload, ramaddr, ramstore} !== '0) begin
      n_err = n_err + 1;
      $display("FAIL rstmid_zero: got ctrl=%b iload=%h dload=%h addr=%h store=%h, required all 0",
               {ihit, dhit, ramREN, ramWEN}, imemload, dmemload, ramaddr, ramstore);
    end
    bad = 0;
    repeat (4) begin
      @(negedge CLK);
      if (ihit || dhit || ramREN) bad++;
    end
    n_cmp = n_cmp + 1;
    if (bad != 0) begin
      n_err = n_err + 1;
      $display("FAIL rstmid_quiet: got %0d active cycles after release, required 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int hits, last, cyc, spacing_bad, ren0;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    sb_q.push_back('{1'b0, 32'h1111_0100});
    sb_q.push_back('{1'b0, 32'h2222_0104});
    sb_q.push_back('{1'b0, 32'h3333_0108});
    ren0 = n_ren;
    hits = 0;
    last = -1;
    cyc  = 0;
    spacing_bad = 0;
    for (int c = 0; c < 20 && hits < 3; c++) begin
      @(negedge CLK);
      cyc++;
      if (ihit) begin
        hits++;
        if (last >= 0 && cyc - last != 3) spacing_bad++;
        last = cyc;
        if (hits == 1) imemaddr = 32'h104;
        else if (hits == 2) imemaddr = 32'h108;
        else imemREN = 1'b0;
      end
    end
    n_cmp = n_cmp + 1;
    if (hits != 3) begin
      n_err = n_err + 1;
      $display("FAIL b2b_count: got %0d ihits, required 3", hits);
    end
    n_cmp = n_cmp + 1;
    if (spacing_bad != 0) begin
      n_err = n_err + 1;
      $display("FAIL b2b_spacing: got %0d gaps not equal to 3 cycles, required 0", spacing_bad);
    end
    @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (n_ren - ren0 != 3) begin
      n_err = n_err + 1;
      $display("FAIL b2b_ram_reads: got %0d ramREN cycles, required 3", n_ren - ren0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h4]   = 32'h2001_0005;
    mem[32'h10]  = 32'h8C22_0000;
    mem[32'h20]  = 32'h3C01_1234;
    mem[32'h80]  = 32'hDEAD_BEEF;
    mem[32'h100] = 32'h1111_0100;
    mem[32'h104] = 32'h2222_0104;
    mem[32'h108] = 32'h3333_0108;

    test_reset();
    test_fetch_basic();
    test_priority();
    test_write_wait();
    test_halt();
    test_reset_mid();
    test_back_to_back();

    repeat (3) @(negedge CLK);
    n_cmp = n_cmp + 1;
    if (sb_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL sb_drain: got %0d pending transactions, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dp_cache_responder.md
Name: dp_cache_responder

Overview:
- Memory-side responder for the pipelined datapath's cache interface.
- Accepts the datapath's instruction-fetch and data read/write requests and serialises them onto one single-ported RAM.
- Returns each result with a one-cycle hit pulse (ihit/dhit) and holds the loaded word.
- Sits between the datapath and the RAM/bus model. It is the stand-in cache until real I/D caches land.

Parameters:
- WORD_W, 32, data and address width in bits.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- halt  in  1  datapath halt. Blocks new instruction fetches.
- imemREN  in  1  instruction read request, held until ihit.
- imemaddr  in  WORD_W  instruction address.
- dmemREN  in  1  data read request, held until dhit.
- dmemWEN  in  1  data write request, held until dhit.
- dmemaddr  in  WORD_W  data address.
- dmemstore  in  WORD_W  data write value.
- ihit  out  1  one-cycle pulse: imemload valid for the served fetch.
- imemload  out  WORD_W  fetched instruction, registered.
- dhit  out  1  one-cycle pulse: data access done; dmemload valid for reads.
- dmemload  out  WORD_W  loaded data word, registered.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data, valid when ram_ready is high.
- ram_ready  in  1  RAM access complete this cycle (variable latency, at least 1 cycle).

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: state=IDLE; ihit, dhit, ramREN, ramWEN = 0; imemload, dmemload, ramaddr, ramstore = 0; latched request = 0.
- FSM states: IDLE, DACC, IACC, DRESP, IRESP.
- IDLE:
  - If dmemREN or dmemWEN, latch dmemaddr, dmemstore and type, then go to DACC.
  - Else, if imemREN and halt is low, latch imemaddr, then go to IACC.
  - Else stay in IDLE.
  - Data has strict priority over instruction. A new request is only sampled in IDLE.
- DACC:
  - ramaddr and ramstore are driven from the latched values.
  - ramREN is high for a read, ramWEN for a write. The two are never high together.
  - If the datapath asserts both dmemREN and dmemWEN, the access is a write.
  - On ram_ready: capture ramload into dmemload (reads only; writes leave dmemload unchanged), drop the strobes, go to DRESP.
- IACC: same as DACC using ramREN and the latched instruction address. On ram_ready, capture into imemload and go to IRESP.
- DRESP: dhit=1 for exactly this cycle, then go to IDLE.
- IRESP: ihit=1 for exactly this cycle, then go to IDLE.
- Purpose of the RESP cycle: the datapath still shows the old request in its hit cycle, and the RESP cycle guarantees that request is not re-issued. The request is sampled again in the IDLE cycle that follows.
- Latency: request seen in IDLE at cycle t. With ram_ready at t+1, hit is high at t+2.
  - Min request-to-hit = 2 cycles plus RAM wait cycles.
  - Back-to-back throughput = 1 access per 3 cycles minimum.
- Hold rules:
  - ihit and dhit are never both high.
  - imemload and dmemload hold their last value between hits.
- Request changes during ACC are ignored; the latched transaction completes and still pulses its hit.
- Halt:
  - A halt asserted while in IACC does not abort the fetch; ihit still pulses.
  - After halt, no IACC is entered, but data requests are still served (pending stores drain).
- ram_ready outside DACC/IACC is ignored.
- Reset mid-transaction: FSM returns to IDLE immediately, strobes drop asynchronously, and no hit is generated for the aborted access.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x0000_0004, RAM returns 0x2001_0005 with ram_ready one cycle after ramREN -> ihit pulses 1 cycle, 2 cycles after the request; imemload=0x2001_0005; ramREN high exactly 1 cycle.
- imemREN and dmemREN together, dmemaddr=0x80, ramload=0xDEAD_BEEF -> data served first; dhit with dmemload=0xDEAD_BEEF; then the fetch starts in the next IDLE; ihit follows 3+ cycles later; never simultaneous.
- dmemWEN=1, dmemaddr=0xF0, dmemstore=0x1234_5678, ram_ready delayed 4 cycles -> ramWEN high 5 cycles with ramaddr=0xF0, ramstore=0x1234_5678; dhit once; dmemload unchanged.
- halt=1 with imemREN=1 and dmemWEN=1 pending -> store completes with dhit; no ramREN for the fetch afterwards; ihit stays 0 for 20 cycles.
- nRST pulled low in IACC before ram_ready -> ramREN drops the same cycle; no ihit; all outputs read 0 after release.
- Request held across the hit cycle (imemREN=1 continuously, 3 fetches) -> exactly 3 ihit pulses spaced 3 cycles apart with ram_ready at 1 cycle; no duplicate RAM access inside a RESP cycle.
